proc_control_unit: RTL

//  Sequencing control for the multicycle 16-bit processor datapath. Holds the instruction register (IR)
//  and a 4-state FSM (T0..T3). Produces the 3-bit register select for the 8-to-1 16-bit register bus
//  mux (mux S input), the outer bus source select, and the register/A/G load strobes.

---
 rtl/proc_control_unit_pkg.sv | 34 +++
 rtl/proc_control_unit_if.sv | 41 ++++
 rtl/proc_control_unit_dec3to8.sv | 17 +
 rtl/proc_control_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/proc_control_unit_pkg.sv
// Shared types and constants for the processor control unit.
//   opcode_t : instruction opcodes (1xx is reserved and decoded as a nop)
//   state_t  : control FSM states T0..T3
//   BUS_*    : outer bus source select encodings
//   *_HI/_LO : field positions inside the 9-bit instruction register
package proc_pkg;

    typedef enum logic [2:0] {
        MV  = 3'b000,
        MVI = 3'b001,
        ADD = 3'b010,
        SUB = 3'b011
    } opcode_t;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [1:0] BUS_REG = 2'b00;
    localparam logic [1:0] BUS_DIN = 2'b01;
    localparam logic [1:0] BUS_G   = 2'b10;

    localparam int IR_W  = 9;
    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int RX_HI = 5;
    localparam int RX_LO = 3;
    localparam int RY_HI = 2;
    localparam int RY_LO = 0;

endpackage

// File: rtl/proc_control_unit_if.sv
// Connection bundle between the control unit and the datapath.
//   Run, DIN            : datapath/sequencer -> control unit
//   IRin, Rin, Ain, Gin,
//   AddSub, reg_sel,
//   bus_src, Done,
//   instr_cnt, state    : control unit -> datapath (state is for debug/checkers)
// Handshake: Run is a request that is accepted only in T0; acceptance is
// signalled by IRin=1 in that same cycle, and completion by a one-cycle Done.
// Run is don't-care in every other cycle.
interface proc_control_unit_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    import proc_pkg::*;

    logic              Run;
    logic [DATA_W-1:0] DIN;
    logic              IRin;
    logic [7:0]        Rin;
    logic              Ain;
    logic              Gin;
    logic              AddSub;
    logic [2:0]        reg_sel;
    logic [1:0]        bus_src;
    logic              Done;
    logic [CNT_W-1:0]  instr_cnt;
    state_t            state;

    // Control unit side
    modport master (
        input  Run, DIN,
        output IRin, Rin, Ain, Gin, AddSub, reg_sel, bus_src, Done, instr_cnt, state
    );

    // Datapath side
    modport slave (
        output Run, DIN,
        input  IRin, Rin, Ain, Gin, AddSub, reg_sel, bus_src, Done, instr_cnt, state
    );

endinterface

// File: rtl/proc_control_unit_dec3to8.sv
// 3-bit binary to 8-bit one-hot decoder with enable; drives the register
// write enables so that at most one register is ever loaded.
//   en  : enable, output is all zero when low
//   sel : register index
//   y   : one-hot output
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) y[sel] = 1'b1;
    end

endmodule

// File: rtl/proc_control_unit.sv
// Sequencing control for the multicycle 16-bit processor datapath.
// Holds the instruction register and the T0..T3 FSM, and decodes the bus
// selects and load strobes for each step of mv / mvi / add / sub / nop.
//   Clock  : single clock, rising edge
//   Resetn : asynchronous active-low reset
//   bus    : master side of proc_control_unit_if (see interface header)
module proc_control_unit
    import proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    proc_control_unit_if.master  bus
);

    state_t            state;
    logic [IR_W-1:0]   ir;
    logic [CNT_W-1:0]  cnt;

    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       is_alu;

    logic       irin;
    logic       rin_en;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic [2:0] reg_sel;
    logic [1:0] bus_src;
    logic       done;

    // Only the low 9 bits of DIN carry an instruction.
    logic unused_din;
    assign unused_din = ^bus.DIN[DATA_W-1:IR_W];

    assign op     = ir[OP_HI:OP_LO];
    assign rx     = ir[RX_HI:RX_LO];
    assign ry     = ir[RY_HI:RY_LO];
    assign is_alu = (op == ADD) || (op == SUB);

    // Outputs decode straight from state and IR. IRin also looks at Run
    // and is gated by Resetn so nothing is strobed while reset is held.
    always_comb begin
        irin    = 1'b0;
        rin_en  = 1'b0;
        ain     = 1'b0;
        gin     = 1'b0;
        addsub  = 1'b0;
        reg_sel = 3'd0;
        bus_src = BUS_REG;
        done    = 1'b0;
        case (state)
            T0: irin = Resetn && bus.Run;
            T1: begin
                if (is_alu) begin
                    reg_sel = rx;
                    ain     = 1'b1;
                end else if (!op[2]) begin
                    rin_en = 1'b1;
                    done   = 1'b1;
                    if (op == MV) reg_sel = ry;
                    else          bus_src = BUS_DIN;
                end else begin
                    // reserved opcode: complete with no strobes
                    done = 1'b1;
                end
            end
            T2: begin
                reg_sel = ry;
                gin     = 1'b1;
                addsub  = (op == SUB);
            end
            T3: begin
                bus_src = BUS_G;
                rin_en  = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
            ir    <= '0;
            cnt   <= '0;
        end else begin
            if (done) cnt <= cnt + CNT_W'(1);
            case (state)
                T0: if (bus.Run) begin
                    ir    <= bus.DIN[IR_W-1:0];
                    state <= T1;
                end
                T1:      state <= is_alu ? T2 : T0;
                T2:      state <= T3;
                T3:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

    dec3to8 u_rin_dec (
        .en  (rin_en),
        .sel (rx),
        .y   (bus.Rin)
    );

    assign bus.IRin      = irin;
    assign bus.Ain       = ain;
    assign bus.Gin       = gin;
    assign bus.AddSub    = addsub;
    assign bus.reg_sel   = reg_sel;
    assign bus.bus_src   = bus_src;
    assign bus.Done      = done;
    assign bus.instr_cnt = cnt;
    assign bus.state     = state;

endmodule
